fetch_queue_unit: RTL and testbench

//   Parametrised instruction-fetch front end for the RV32IM pipeline.

---
 rtl/fetch_queue_unit.sv | 134 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction-fetch front end. Owns the fetch PC, issues sequential
//            requests to the instruction cache, buffers {PC, instruction}
//            pairs in a DEPTH-entry FIFO and hands them to decode through a
//            valid/ready handshake. EX redirects flush the queue and restart
//            fetch at the word-aligned target.
// Options  : `define FETCH_BYPASS_EN to forward a completing fetch straight to
//            decode when the queue is empty (zero-cycle fetch-to-decode).
//            Without it, every entry passes through the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
  parameter int                XLEN         = 32,
  parameter int                DEPTH        = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [XLEN-1:0]   INST_ADDRESS,
  output logic              INST_REQ,
  input  logic [XLEN-1:0]   INSTRUCTION,
  input  logic              INST_BUSYWAIT,
  input  logic              REDIRECT,
  input  logic [XLEN-1:0]   REDIRECT_PC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [XLEN-1:0]   OUT_PC,
  output logic [XLEN-1:0]   OUT_INST,
  output logic [15:0]       FLUSH_COUNT
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [AW:0]     c_DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   c_PTR_ONE   = AW'(1);
  localparam logic [XLEN-1:0] c_PC_STEP   = XLEN'(4);
  localparam logic [15:0]     c_FLUSH_MAX = 16'hFFFF;

  // Queue storage and bookkeeping
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic [XLEN-1:0] r_fetch_pc;
  logic [15:0]     r_flush_count;

  logic w_full;
  logic w_empty;
  logic w_fetch;
  logic w_push;
  logic w_pop;
  logic w_bypass_take;

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // A redirect cycle never requests: the address is about to change.
  assign INST_REQ     = ~w_full & ~REDIRECT;
  assign INST_ADDRESS = r_fetch_pc;
  assign w_fetch      = INST_REQ & ~INST_BUSYWAIT;
  assign FLUSH_COUNT  = r_flush_count;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  // A completing fetch into an empty queue is shown to decode immediately;
  // it only lands in the FIFO if decode does not take it this cycle.
  assign w_bypass      = w_fetch & w_empty;
  assign w_bypass_take = w_bypass & OUT_READY;
  assign OUT_VALID     = ~w_empty | w_bypass;
  assign OUT_PC        = w_bypass ? r_fetch_pc  : r_pc_mem[r_rd_ptr];
  assign OUT_INST      = w_bypass ? INSTRUCTION : r_inst_mem[r_rd_ptr];
`else
  assign w_bypass_take = 1'b0;
  assign OUT_VALID     = ~w_empty;
  assign OUT_PC        = r_pc_mem[r_rd_ptr];
  assign OUT_INST      = r_inst_mem[r_rd_ptr];
`endif

  // Redirect kills any push or pop of the same cycle (handled in the update).
  assign w_push = w_fetch & ~w_bypass_take;
  assign w_pop  = ~w_empty & OUT_READY;

  // Entry storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= INSTRUCTION;
    end
  end

  // Pointers, occupancy, fetch PC and redirect counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_pc    <= RESET_VECTOR;
      r_flush_count <= '0;
    end else if (REDIRECT) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= {REDIRECT_PC[XLEN-1:2], 2'b00};
      if (r_flush_count != c_FLUSH_MAX) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end else begin
      if (w_fetch) begin
        r_fetch_pc <= r_fetch_pc + c_PC_STEP;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Self-checking bench for fetch_queue_unit (default build, no
//            bypass). Directed scenarios followed by randomized traffic, all
//            checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INST_ADDRESS;
  logic        INST_REQ;
  logic [31:0] INSTRUCTION;
  logic        INST_BUSYWAIT;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_INST;
  logic [15:0] FLUSH_COUNT;

  always #5 CLK = ~CLK;

  fetch_queue_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .INST_ADDRESS(INST_ADDRESS), .INST_REQ(INST_REQ),
    .INSTRUCTION(INSTRUCTION), .INST_BUSYWAIT(INST_BUSYWAIT),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_INST(OUT_INST),
    .FLUSH_COUNT(FLUSH_COUNT)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of {pc, inst} plus the fetch PC.
  logic [63:0] q[$];
  logic [31:0] m_pc    = RV;
  logic [15:0] m_flush = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model for the current inputs, clock once,
  // then advance the model with the inputs seen at the edge.
  task automatic cycle();
    bit req, fetch, pop;
    #1;
    req   = (q.size() < DEPTH) && !REDIRECT;
    fetch = req && !INST_BUSYWAIT;
    pop   = (q.size() != 0) && OUT_READY;
    if (!RESET) begin
      chk("valid", {31'b0, OUT_VALID}, {31'b0, q.size() != 0});
      chk("req", {31'b0, INST_REQ}, {31'b0, req});
      chk("addr", INST_ADDRESS, m_pc);
      chk("flush", {16'b0, FLUSH_COUNT}, {16'b0, m_flush});
      if (q.size() != 0) begin
        chk("head_pc", OUT_PC, q[0][63:32]);
        chk("head_inst", OUT_INST, q[0][31:0]);
      end
    end
    @(posedge CLK);
    if (RESET) begin
      q.delete();
      m_pc    = RV;
      m_flush = '0;
    end else if (REDIRECT) begin
      q.delete();
      m_pc = {REDIRECT_PC[31:2], 2'b00};
      if (m_flush != 16'hFFFF) m_flush++;
    end else begin
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back({m_pc, INSTRUCTION});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    INSTRUCTION = $urandom;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cycle();
    cycle();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; INSTRUCTION = $urandom; INST_BUSYWAIT = 1'b0;
    REDIRECT = 1'b0; REDIRECT_PC = '0; OUT_READY = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_req", {31'b0, INST_REQ}, 32'd1);
    chk("rst_addr", INST_ADDRESS, RV);
    chk("rst_out_pc", OUT_PC, 32'd0);
    chk("rst_out_inst", OUT_INST, 32'd0);
    chk("rst_flush", {16'b0, FLUSH_COUNT}, 32'd0);

    // Streaming with decode always ready: heads 0,4,8,12 one per cycle
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("t1_head", OUT_PC, 32'(i * 4));
      cycle();
    end

    // Stall at PC=8, then fill the queue with decode blocked
    do_reset();
    OUT_READY = 1'b0;
    cycle(); cycle();
    INST_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_addr_hold", INST_ADDRESS, 32'd8);
    end
    INST_BUSYWAIT = 1'b0;
    cycle();
    chk("t3_addr_after", INST_ADDRESS, 32'd12);
    cycle();
    chk("t2_full_req", {31'b0, INST_REQ}, 32'd0);
    chk("t2_full_addr", INST_ADDRESS, 32'd16);
    cycle();
    chk("t2_full_hold", INST_ADDRESS, 32'd16);
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_drain", OUT_PC, 32'(i * 4));
      cycle();
    end

    // Redirect with queue holding 0,4,8
    do_reset();
    OUT_READY = 1'b0;
    cycle(); cycle(); cycle();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    #1 chk("t4_req_low", {31'b0, INST_REQ}, 32'd0);
    cycle();
    REDIRECT = 1'b0;
    chk("t4_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("t4_addr", INST_ADDRESS, 32'h100);
    chk("t4_flush", {16'b0, FLUSH_COUNT}, 32'd1);
    cycle();
    chk("t4_head", OUT_PC, 32'h100);

    // PC wrap at top of address space
    OUT_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFE;
    cycle();
    REDIRECT = 1'b0;
    chk("t5_addr_top", INST_ADDRESS, 32'hFFFF_FFFC);
    cycle();
    chk("t5_addr_wrap", INST_ADDRESS, 32'h0);

    // Reset while full and stalled
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    INST_BUSYWAIT = 1'b1;
    cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    chk("t6_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("t6_addr", INST_ADDRESS, RV);
    chk("t6_flush", {16'b0, FLUSH_COUNT}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      OUT_READY     = ($urandom_range(0, 99) < 60);
      INST_BUSYWAIT = ($urandom_range(0, 99) < 30);
      REDIRECT      = ($urandom_range(0, 99) < 8);
      REDIRECT_PC   = $urandom;
      RESET         = ($urandom_range(0, 199) == 0);
      cycle();
    end
    RESET = 1'b0; REDIRECT = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
